// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command sequencer: FSM state encoding,
// the status code reported on a timeout, and the packed command-entry width.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_RESP
    } seq_state_t;

    localparam logic [3:0] STATUS_TIMEOUT = 4'hF;

    // One queued command is {rw, chip_addr[6:0], reg_addr, wdata}.
    function automatic int cmd_entry_width(input int addr_bytes, input int data_bytes);
        return 1 + 7 + 8 * addr_bytes + 8 * data_bytes;
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Small synchronous FIFO holding queued I2C commands. Full/empty flags are
// registered so cmd_ready never depends combinationally on the pop side.
module i2c_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      next_count;
    logic             do_push;
    logic             do_pop;

    // A push is refused while full even if a pop happens in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; drives the registered flags.
    always_comb begin
        next_count = count;
        case ({do_push, do_pop})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    // Storage array is written on accepted pushes only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;
            full  <= (next_count == (PW + 1)'(DEPTH));
            empty <= (next_count == '0);
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command stage in front of i2c_master: queues read/write commands, issues
// them one at a time, and returns one response per command in order.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int ADDR_BYTES    = 1,
    parameter int DATA_BYTES    = 2,
    parameter int CMD_DEPTH     = 4,
    parameter int START_TIMEOUT = 16,
    parameter int XFER_TIMEOUT  = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rw,
    input  logic [6:0]                    cmd_chip_addr,
    input  logic [8*ADDR_BYTES-1:0]       cmd_reg_addr,
    input  logic [8*DATA_BYTES-1:0]       cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [8*DATA_BYTES-1:0]       rsp_rdata,
    output logic [3:0]                    rsp_status,
    output logic                          rsp_timeout,
    output logic [6:0]                    m_chip_addr,
    output logic [8*ADDR_BYTES-1:0]       m_reg_addr,
    output logic [8*DATA_BYTES-1:0]       m_data_in,
    output logic                          m_read_en,
    output logic                          m_write_en,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic [3:0]                    m_status,
    input  logic [8*DATA_BYTES-1:0]       m_data_out,
    output logic [$clog2(CMD_DEPTH):0]    pending
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int EW = cmd_entry_width(ADDR_BYTES, DATA_BYTES);
    localparam int TW = $clog2(XFER_TIMEOUT + 1);

    localparam logic [TW-1:0] START_LIMIT = TW'(START_TIMEOUT);
    localparam logic [TW-1:0] XFER_LIMIT  = TW'(XFER_TIMEOUT);

    seq_state_t      state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_inc;
    logic            busy_q;
    logic            cur_rw;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [EW-1:0]   fifo_in;
    logic [EW-1:0]   head;
    logic            head_rw;
    logic [6:0]      head_chip;
    logic [AW-1:0]   head_reg;
    logic [DW-1:0]   head_data;
    logic            xfer_complete;

    assign fifo_in   = {cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_wdata};
    assign head_rw   = head[EW-1];
    assign head_chip = head[EW-2 -: 7];
    assign head_reg  = head[DW +: AW];
    assign head_data = head[DW-1:0];
    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_ISSUE);
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

    // Either an explicit done pulse or busy dropping ends the transfer.
    assign xfer_complete = m_done || (busy_q && !m_busy);

    i2c_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    // Delayed copy of m_busy so a falling edge can be recognised as completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= m_busy;
        end
    end

    // Sequencer FSM: issue one command, wait for the master, hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cur_rw      <= 1'b0;
            m_chip_addr <= '0;
            m_reg_addr  <= '0;
            m_data_in   <= '0;
            m_read_en   <= 1'b0;
            m_write_en  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            m_read_en  <= 1'b0;
            m_write_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && !m_busy) begin
                        state <= ST_ISSUE;
                        timer <= '0;
                    end
                end
                ST_ISSUE: begin
                    m_chip_addr <= head_chip;
                    m_reg_addr  <= head_reg;
                    m_data_in   <= head_data;
                    m_read_en   <= head_rw;
                    m_write_en  <= !head_rw;
                    cur_rw      <= head_rw;
                    timer       <= '0;
                    state       <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (m_busy) begin
                        state <= ST_WAIT_DONE;
                        timer <= '0;
                    end else if (timer >= START_LIMIT) begin
                        rsp_status  <= STATUS_TIMEOUT;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        timer       <= '0;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    if (xfer_complete) begin
                        rsp_status  <= m_status;
                        rsp_rdata   <= cur_rw ? m_data_out : '0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        timer       <= '0;
                        state       <= ST_RESP;
                    end else if (timer >= XFER_LIMIT) begin
                        rsp_status  <= STATUS_TIMEOUT;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        timer       <= '0;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        timer     <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer. A behavioural i2c_master stand-in
// serves a slave at 0x0F, a NACKing device at 0x33 and nothing at 0x22; a
// scoreboard predicts every response from the slave memory contents.
module tb_i2c_cmd_sequencer;

    localparam logic [6:0] SLAVE_CHIP  = 7'h0F;
    localparam logic [6:0] NACK_CHIP   = 7'h33;
    localparam logic [6:0] NO_DEV_CHIP = 7'h22;
    localparam int         BUDGET      = 4000;

    typedef struct {
        bit          rw;
        logic [6:0]  chip;
        logic [7:0]  reg_a;
        logic [15:0] wdata;
        logic [20:0] rsp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_chip_addr;
    logic [7:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic [3:0]  rsp_status;
    logic        rsp_timeout;
    logic [6:0]  m_chip_addr;
    logic [7:0]  m_reg_addr;
    logic [15:0] m_data_in;
    logic        m_read_en;
    logic        m_write_en;
    logic        m_busy;
    logic        m_done;
    logic [3:0]  m_status;
    logic [15:0] m_data_out;
    logic [2:0]  pending;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted     = 0;
    int discarded    = 0;
    int rsp_count    = 0;
    int strobe_since = 0;
    int rsp_mode     = 1;   // 0 random ready, 1 always ready, 2 hold off
    bit stub_slow    = 0;

    exp_t        sb[$];
    logic [15:0] ref_mem   [256];
    logic [15:0] slave_mem [256];

    i2c_cmd_sequencer #(
        .ADDR_BYTES    (1),
        .DATA_BYTES    (2),
        .CMD_DEPTH     (4),
        .START_TIMEOUT (16),
        .XFER_TIMEOUT  (65535)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_chip_addr (cmd_chip_addr),
        .cmd_reg_addr  (cmd_reg_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_status    (rsp_status),
        .rsp_timeout   (rsp_timeout),
        .m_chip_addr   (m_chip_addr),
        .m_reg_addr    (m_reg_addr),
        .m_data_in     (m_data_in),
        .m_read_en     (m_read_en),
        .m_write_en    (m_write_en),
        .m_busy        (m_busy),
        .m_done        (m_done),
        .m_status      (m_status),
        .m_data_out    (m_data_out),
        .pending       (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour of the whole system for one accepted command.
    function automatic exp_t modelAccept(input bit rw, input logic [6:0] chip,
                                         input logic [7:0] ra, input logic [15:0] wd);
        exp_t e;
        e.rw = rw; e.chip = chip; e.reg_a = ra; e.wdata = wd;
        if (chip == SLAVE_CHIP) begin
            if (rw) begin
                e.rsp = {ref_mem[ra], 4'h0, 1'b0};
            end else begin
                e.rsp = {16'h0, 4'h0, 1'b0};
                ref_mem[ra] = wd;
            end
        end else if (chip == NACK_CHIP) begin
            e.rsp = {(rw ? 16'hDEAD : 16'h0), 4'h3, 1'b0};
        end else begin
            e.rsp = {16'h0, 4'hF, 1'b1};
        end
        return e;
    endfunction

    // Offer one command (called at a negedge); returns at the negedge after acceptance.
    task automatic applyStimulus(input bit rw, input logic [6:0] chip,
                                 input logic [7:0] ra, input logic [15:0] wd);
        int b = 0;
        cmd_rw = rw; cmd_chip_addr = chip; cmd_reg_addr = ra; cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        if (b >= BUDGET) begin
            checkOutput("cmd_accept", 32'd0, 32'd1);
        end else begin
            sb.push_back(modelAccept(rw, chip, ra, wd));
            accepted++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int b = 0;
        while (!(sb.size() == 0 && pending == 0 && !rsp_valid) && b < BUDGET) begin
            @(negedge clk);
            b++;
        end
        checkOutput(tag, 32'(b < BUDGET), 32'd1);
    endtask

    // Behavioural i2c_master stand-in driven on the falling edge.
    initial begin : stub
        int          phase;
        int          cnt;
        bit          st_rw;
        logic [6:0]  st_chip;
        logic [7:0]  st_reg;
        logic [15:0] st_wdata;
        logic [31:0] rnd;
        phase = 0; cnt = 0;
        m_busy = 1'b0; m_done = 1'b0; m_status = 4'h0; m_data_out = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 0; m_busy = 1'b0; m_done = 1'b0;
                continue;
            end
            m_done = 1'b0;
            if (phase == 0 && (m_read_en || m_write_en)) begin
                st_rw = m_read_en; st_chip = m_chip_addr; st_reg = m_reg_addr; st_wdata = m_data_in;
                if (st_chip == SLAVE_CHIP || st_chip == NACK_CHIP) begin
                    cnt = $urandom_range(0, 2);
                    phase = 1;
                end
            end
            if (phase == 1) begin
                if (cnt == 0) begin
                    m_busy = 1'b1;
                    cnt = stub_slow ? 20 : $urandom_range(1, 5);
                    phase = 2;
                end else begin
                    cnt--;
                end
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    m_status = (st_chip == SLAVE_CHIP) ? 4'h0 : 4'h3;
                    rnd = $urandom;
                    m_data_out = rnd[15:0];
                    if (st_rw) begin
                        m_data_out = (st_chip == SLAVE_CHIP) ? slave_mem[st_reg] : 16'hDEAD;
                    end else if (st_chip == SLAVE_CHIP) begin
                        slave_mem[st_reg] = st_wdata;
                    end
                    m_busy = 1'b0;
                    if ($urandom_range(0, 1) == 1) m_done = 1'b1;
                    phase = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Response side: drives rsp_ready and checks strobes and responses against the scoreboard.
    initial begin : monitor
        exp_t e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_ready = 1'b0;
                continue;
            end
            if (m_read_en || m_write_en) begin
                strobe_since++;
                if (sb.size() == 0) begin
                    checkOutput("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    checkOutput("strobe_rw", 32'({m_read_en, m_write_en}), 32'({e.rw, !e.rw}));
                    checkOutput("strobe_addr", 32'({m_chip_addr, m_reg_addr}), 32'({e.chip, e.reg_a}));
                    if (!e.rw) checkOutput("strobe_wdata", 32'(m_data_in), 32'(e.wdata));
                end
            end
            rsp_ready = (rsp_mode == 2) ? 1'b0 :
                        (rsp_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("rsp_fields", 32'({rsp_rdata, rsp_status, rsp_timeout}), 32'(sb[0].rsp));
                    if (rsp_ready) begin
                        checkOutput("strobes_per_cmd", 32'(strobe_since), 32'd1);
                        strobe_since = 0;
                        void'(sb.pop_front());
                        rsp_count++;
                    end
                end
            end
        end
    end

    // Main sequence of directed scenarios followed by a randomized run.
    initial begin : main
        logic [7:0]  regs [4];
        logic [31:0] rnd;
        int          b;
        regs[0] = 8'h00; regs[1] = 8'h0A; regs[2] = 8'h10; regs[3] = 8'h1A;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'h0;
            slave_mem[i] = 16'h0;
        end
        ref_mem[8'h00] = 16'hA1A1; ref_mem[8'h0A] = 16'hB2B2;
        ref_mem[8'h10] = 16'hC3C3; ref_mem[8'h1A] = 16'hD4D4;
        for (int i = 0; i < 256; i++) slave_mem[i] = ref_mem[i];

        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0;
        cmd_chip_addr = 7'h0; cmd_reg_addr = 8'h0; cmd_wdata = 16'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rsp", 32'({rsp_valid, rsp_rdata, rsp_status, rsp_timeout}), 32'd0);
        checkOutput("rst_m_en", 32'({m_read_en, m_write_en}), 32'd0);
        checkOutput("rst_m_fields", 32'({m_chip_addr, m_reg_addr, m_data_in}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Issue latency: accepted at one edge, strobe visible after the second edge later.
        rsp_mode = 1;
        applyStimulus(1'b1, SLAVE_CHIP, 8'h00, 16'h0);
        checkOutput("lat_early", 32'(m_read_en), 32'd0);
        @(negedge clk);
        checkOutput("lat_early2", 32'(m_read_en), 32'd0);
        @(negedge clk);
        checkOutput("lat_strobe", 32'(m_read_en), 32'd1);
        waitDrain("drain_latency");

        // Back-to-back reads of the four populated registers.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, SLAVE_CHIP, regs[i], 16'h0);
        waitDrain("drain_b2b");

        // Write then read back.
        applyStimulus(1'b0, SLAVE_CHIP, 8'h0A, 16'h5A5A);
        applyStimulus(1'b1, SLAVE_CHIP, 8'h0A, 16'h0);
        waitDrain("drain_wr_rd");

        // Absent device times out; the following command still completes.
        applyStimulus(1'b1, NO_DEV_CHIP, 8'h10, 16'h0);
        applyStimulus(1'b1, SLAVE_CHIP, 8'h10, 16'h0);
        waitDrain("drain_timeout");

        // FIFO full: first command parked in RESP, four more fill the queue.
        rsp_mode = 2;
        applyStimulus(1'b1, SLAVE_CHIP, 8'h00, 16'h0);
        b = 0;
        while (!rsp_valid && b < BUDGET) begin @(negedge clk); b++; end
        checkOutput("full_first_rsp", 32'(b < BUDGET), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, SLAVE_CHIP, regs[(i + 1) % 4], 16'h0);
        checkOutput("full_pending", 32'(pending), 32'd4);
        checkOutput("full_ready", 32'(cmd_ready), 32'd0);
        cmd_rw = 1'b0; cmd_chip_addr = SLAVE_CHIP; cmd_reg_addr = 8'h1A; cmd_wdata = 16'h7E57;
        cmd_valid = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("full_hold_pending", 32'(pending), 32'd4);
        cmd_valid = 1'b0;
        rsp_mode = 1;
        applyStimulus(1'b0, SLAVE_CHIP, 8'h1A, 16'h7E57);
        applyStimulus(1'b1, SLAVE_CHIP, 8'h1A, 16'h0);
        waitDrain("drain_full");

        // Held response must stay stable and block the next issue.
        rsp_mode = 2;
        applyStimulus(1'b1, SLAVE_CHIP, 8'h10, 16'h0);
        applyStimulus(1'b1, SLAVE_CHIP, 8'h00, 16'h0);
        repeat (50) @(negedge clk);
        checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
        checkOutput("hold_pending", 32'(pending), 32'd1);
        rsp_mode = 1;
        waitDrain("drain_hold");

        // Reset while a transfer is in WAIT_DONE with three more queued.
        stub_slow = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, SLAVE_CHIP, regs[i], 16'h0);
        b = 0;
        while (!m_busy && b < BUDGET) begin @(negedge clk); b++; end
        checkOutput("rst_mid_busy", 32'(b < BUDGET), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_pending", 32'(pending), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_pending", 32'(pending), 32'd0);
        checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_read_en", 32'(m_read_en), 32'd0);
        repeat (2) @(negedge clk);
        discarded += sb.size();
        sb.delete();
        strobe_since = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = slave_mem[i];
        stub_slow = 0;
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, SLAVE_CHIP, 8'h0A, 16'h0);
        waitDrain("drain_after_rst");

        // Randomized traffic with random response back-pressure.
        rsp_mode = 0;
        for (int n = 0; n < 40; n++) begin
            logic [6:0] chip;
            logic [7:0] ra;
            int         pick;
            pick = $urandom_range(0, 9);
            chip = (pick == 0) ? NO_DEV_CHIP : (pick == 1) ? NACK_CHIP : SLAVE_CHIP;
            rnd = $urandom;
            ra = (pick > 5) ? rnd[23:16] : regs[rnd[1:0]];
            applyStimulus(bit'($urandom_range(0, 1)), chip, ra, rnd[15:0]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rsp_mode = 1;
        waitDrain("drain_random");

        checkOutput("rsp_total", 32'(rsp_count), 32'(accepted - discarded));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Upstream command stage for i2c_master. It accepts I2C register read/write commands over a valid/ready stream and buffers them in a small FIFO. It issues the commands one at a time to i2c_master through that block's chip_addr/reg_addr/data_in/read_en/write_en interface, then returns one response per command carrying read data and status. Software or a host-bus bridge can therefore queue transfers without polling master_busy.

Parameters:
ADDR_BYTES, 1, register-address width in bytes; must match i2c_master.
DATA_BYTES, 2, data width in bytes; must match i2c_master.
CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
START_TIMEOUT, 16, clk cycles allowed after issue for m_busy to assert.
XFER_TIMEOUT, 65535, clk cycles allowed while m_busy is high.

Ports:
clk  in  1  single clock; master and sequencer share it.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO not full.
cmd_rw  in  1  1 = read, 0 = write.
cmd_chip_addr  in  7  target chip address.
cmd_reg_addr  in  8*ADDR_BYTES  register address.
cmd_wdata  in  8*DATA_BYTES  write data; ignored for reads.
rsp_valid  out  1  response held.
rsp_ready  in  1  response accepted.
rsp_rdata  out  8*DATA_BYTES  read data; 0 for writes.
rsp_status  out  4  m_status captured at completion; 4'hF on timeout.
rsp_timeout  out  1  response produced by timeout.
m_chip_addr  out  7  to i2c_master chip_addr.
m_reg_addr  out  8*ADDR_BYTES  to i2c_master reg_addr.
m_data_in  out  8*DATA_BYTES  to i2c_master data_in.
m_read_en  out  1  one-cycle read strobe.
m_write_en  out  1  one-cycle write strobe.
m_busy  in  1  from i2c_master busy.
m_done  in  1  from i2c_master done.
m_status  in  4  from i2c_master status.
m_data_out  in  8*DATA_BYTES  from i2c_master data_out.
pending  out  $clog2(CMD_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high), all outputs:
  - FIFO empty, pending = 0, cmd_ready = 1.
  - rsp_valid = 0, rsp_rdata / rsp_status / rsp_timeout = 0.
  - m_read_en = m_write_en = 0; m_chip_addr / m_reg_addr / m_data_in = 0.
  - FSM in IDLE.
- FIFO push/pop rules:
  - Push on cmd_valid & cmd_ready. cmd_ready = !full, registered; no push is accepted while full, even when a pop occurs in the same cycle.
  - Pointers wrap modulo CMD_DEPTH.
  - A simultaneous push and pop leaves pending unchanged.
- FSM states:
  - IDLE: when FIFO is non-empty and m_busy = 0, go to ISSUE.
  - ISSUE (1 cycle): drive head fields onto m_* ports, pulse m_read_en (rw = 1) or m_write_en (rw = 0) for exactly one cycle, pop the FIFO, clear the timer, go to WAIT_START. m_* address/data outputs hold their values until the next ISSUE.
  - WAIT_START: when m_busy = 1, go to WAIT_DONE and clear the timer. When the timer reaches START_TIMEOUT first, take the timeout path.
  - WAIT_DONE: completion is m_done = 1, or m_busy falling (registered 1→0), whichever comes first. On completion, capture m_status into rsp_status; capture m_data_out into rsp_rdata for reads only (0 for writes); set rsp_timeout = 0; go to RESP. When the timer reaches XFER_TIMEOUT first, take the timeout path.
  - Timeout path: rsp_status = 4'hF, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
  - RESP: rsp_valid = 1, response fields held stable. On rsp_ready, drop rsp_valid next cycle and go to IDLE. Issue stalls until the response is accepted, so at most one command is in flight.
- Latency and throughput:
  - Command accepted into an empty FIFO while idle → m_*_en strobe 2 cycles later.
  - Completion → rsp_valid on the next cycle.
- Timer: saturating, $clog2(XFER_TIMEOUT+1) bits, cleared on every state entry.
- Ordering: responses are returned in command order.
- Reset mid-transfer: the sequencer returns to IDLE immediately and the queued commands are discarded. i2c_master is reset by the same net.

Decomposition:
- Shared package i2c_pkg holds:
  - FSM state encoding (IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP);
  - the STATUS_TIMEOUT = 4'hF constant;
  - the command-entry width function (1 + 7 + 8*ADDR_BYTES + 8*DATA_BYTES).
- One sub-module: i2c_cmd_fifo. Synchronous FIFO with registered full/empty flags and a count output, parameterised by width and depth.

Test Plan:
- Bench setup: i2c_master + i2c_slave, slave chip 0x0F, slave memory {0x00: A1A1, 0x0A: B2B2, 0x10: C3C3, 0x1A: D4D4}.
- Queue reads of 0x00, 0x0A, 0x10, 0x1A back-to-back with rsp_ready = 1 → responses in order A1A1, B2B2, C3C3, D4D4, all with rsp_timeout = 0; exactly one m_read_en pulse per command.
- Push 5 commands with CMD_DEPTH = 4 while the first is in flight → cmd_ready = 0 at pending = 4; the 5th is accepted only after a pop; no command is lost or duplicated.
- Write 0x5A5A to reg 0x0A, then read 0x0A → write response rdata = 0; read response rdata = 5A5A.
- Command to chip 0x22 with m_busy forced low (master stubbed) → after START_TIMEOUT = 16 cycles: rsp_status = F, rsp_timeout = 1; the next queued command still issues.
- Hold rsp_ready = 0 for 50 cycles with 2 queued reads → rsp_valid and rsp_rdata stable; no second m_read_en until the first response is accepted.
- Assert reset during WAIT_DONE with 3 commands pending → pending = 0, rsp_valid = 0, m_read_en = 0 within the same cycle; a new read after reset returns correct data.
